// File: rtl/switch_frame_packer.sv
// Frames 10-word switch serializer bursts into sync/count/payload/sum packets.
// Ports: sys_clk_100m, rst_i (sync high) | wr_din_i, wr_en_i | m_* stream | frame_cnt_o, drop_cnt_o, short_err_o
module switch_frame_packer #(
  parameter int          WORDS_PER_FRAME = 10,
  parameter int          FIFO_DEPTH      = 32,
  parameter logic [15:0] SYNC_WORD       = 16'hEB90
) (
  input  logic        sys_clk_100m,
  input  logic        rst_i,
  input  logic [15:0] wr_din_i,
  input  logic        wr_en_i,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] drop_cnt_o,
  output logic        short_err_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WIW = $clog2(WORDS_PER_FRAME + 1);

  localparam logic [WIW-1:0] WI_LAST =
    WIW'(WORDS_PER_FRAME - 1);
  localparam logic [AW:0] WPF_W =
    (AW+1)'(WORDS_PER_FRAME);
  // A new frame fits when used words leave room for a full frame.
  localparam logic [AW:0] MAX_USED =
    (AW+1)'(FIFO_DEPTH - WORDS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_CNT,
    S_PAY,
    S_SUM
  } state_t;

  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW:0]    wr_tent;
  logic [AW:0]    wr_cmt;
  logic [AW:0]    rd_ptr;
  logic [WIW-1:0] wi;
  logic           drop_q;

  logic [AW:0]    used;
  logic [AW:0]    occ;
  logic           wr_first;
  logic           wr_last;
  logic           accept_now;
  logic           take;

  state_t         state;
  state_t         state_nx;
  logic [WIW-1:0] pidx;
  logic [15:0]    sum_q;
  logic           avail_q;
  logic           xfer;
  logic           more;

  // Write side

  // Tentative words count against free space so an open frame
  // can never be overrun by the next one.
  assign used       = wr_tent - rd_ptr;
  assign accept_now = used <= MAX_USED;
  assign wr_first   = wr_en_i && (wi == '0);
  assign wr_last    = wr_en_i && (wi == WI_LAST);
  assign take       = wr_en_i &&
                      (wr_first ? accept_now : !drop_q);

  always_ff @(posedge sys_clk_100m) begin
    if (take) begin
      mem[wr_tent[AW-1:0]] <= wr_din_i;
    end
  end

  always_ff @(posedge sys_clk_100m) begin
    if (rst_i) begin
      wr_tent     <= '0;
      wr_cmt      <= '0;
      wi          <= '0;
      drop_q      <= 1'b0;
      drop_cnt_o  <= '0;
      short_err_o <= 1'b0;
    end else begin
      short_err_o <= 1'b0;
      if (wr_en_i) begin
        if (wr_first) begin
          drop_q <= !accept_now;
          if (!accept_now && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
          end
        end
        if (take) begin
          wr_tent <= wr_tent + 1'b1;
        end
        if (wr_last) begin
          wi <= '0;
          if (take) begin
            wr_cmt <= wr_tent + 1'b1;
          end
        end else begin
          wi <= wi + WIW'(1);
        end
      end else if (wi != '0) begin
        // Burst ended early: roll back the open frame.
        wi          <= '0;
        wr_tent     <= wr_cmt;
        short_err_o <= !drop_q;
      end
    end
  end

  // Read side

  assign occ  = wr_cmt - rd_ptr;
  assign more = occ >= WPF_W;
  assign xfer = m_valid_o && m_ready_i;

  always_ff @(posedge sys_clk_100m) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // IDLE waits on a registered availability flag, which gives
  // the two-cycle commit-to-header latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (avail_q) state_nx = S_HEAD;
      S_HEAD: if (xfer) state_nx = S_CNT;
      S_CNT:  if (xfer) state_nx = S_PAY;
      S_PAY:  if (xfer && pidx == WI_LAST) state_nx = S_SUM;
      S_SUM:  if (xfer) state_nx = more ? S_HEAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_100m) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      pidx        <= '0;
      sum_q       <= '0;
      avail_q     <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      avail_q <= more;
      unique case (state)
        S_HEAD: begin
          pidx  <= '0;
          sum_q <= '0;
        end
        S_PAY: begin
          if (xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            pidx   <= pidx + WIW'(1);
            sum_q  <= sum_q + m_data_o;
          end
        end
        S_SUM: begin
          if (xfer) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = '0;
    unique case (state)
      S_HEAD: begin
        m_valid_o = 1'b1;
        m_data_o  = SYNC_WORD;
      end
      S_CNT: begin
        m_valid_o = 1'b1;
        m_data_o  = frame_cnt_o;
      end
      S_PAY: begin
        m_valid_o = 1'b1;
        m_data_o  = mem[rd_ptr[AW-1:0]];
      end
      S_SUM: begin
        m_valid_o = 1'b1;
        m_last_o  = 1'b1;
        m_data_o  = sum_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_switch_frame_packer.sv
// Directed bench for switch_frame_packer.
// Checks framing, drops, short bursts, stalls and reset.
module tb_switch_frame_packer;

  logic        sys_clk_100m = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] wr_din_i = '0;
  logic        wr_en_i = 1'b0;
  logic [15:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic        m_last_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] drop_cnt_o;
  logic        short_err_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] got  [16];
  logic        lastf[16];
  int          nw;
  int          gap;

  switch_frame_packer dut (
    .sys_clk_100m (sys_clk_100m),
    .rst_i        (rst_i),
    .wr_din_i     (wr_din_i),
    .wr_en_i      (wr_en_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .frame_cnt_o  (frame_cnt_o),
    .drop_cnt_o   (drop_cnt_o),
    .short_err_o  (short_err_o)
  );

  always #5 sys_clk_100m = ~sys_clk_100m;

  task automatic step();
    @(posedge sys_clk_100m);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic burst(input logic [15:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      wr_en_i  = 1'b1;
      wr_din_i = base + 16'(i);
      step();
    end
    wr_en_i  = 1'b0;
    wr_din_i = '0;
  endtask

  // Gathers one frame; optional ready pattern with stall checks.
  task automatic collect(input int budget, input bit pat);
    bit          done;
    bit          held;
    logic [15:0] hd;
    done = 0;
    held = 0;
    hd   = '0;
    nw   = 0;
    gap  = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (pat) m_ready_i = (c % 3) != 1;
      if (held && m_valid_o) chk("stall_hold", m_data_o, hd);
      held = m_valid_o && !m_ready_i;
      hd   = m_data_o;
      if (m_valid_o && m_ready_i) begin
        if (nw < 16) begin
          got[nw]   = m_data_o;
          lastf[nw] = m_last_o;
        end
        nw++;
        if (m_last_o || nw >= 16) done = 1;
      end else if (nw == 0) begin
        gap++;
      end
      step();
    end
    if (pat) m_ready_i = 1'b1;
  endtask

  task automatic check_frame(input string tag,
                             input logic [15:0] base,
                             input logic [15:0] cnt);
    logic [15:0] s;
    int          nl;
    s  = '0;
    nl = 0;
    chk({tag, "_len"}, 16'(nw), 16'd13);
    chk({tag, "_sync"}, got[0], 16'hEB90);
    chk({tag, "_cnt"}, got[1], cnt);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("%s_pay%0d", tag, i), got[i+1],
          base + 16'(i));
      s = s + base + 16'(i);
    end
    chk({tag, "_sum"}, got[12], s);
    for (int i = 0; i < 13; i++) nl += int'(lastf[i]);
    chk({tag, "_lastpos"}, 16'(lastf[12]), 16'd1);
    chk({tag, "_lastcnt"}, 16'(nl), 16'd1);
  endtask

  initial begin
    step();
    do_reset();
    chk("rst_valid", 16'(m_valid_o), 16'd0);
    chk("rst_data", m_data_o, 16'h0000);
    chk("rst_last", 16'(m_last_o), 16'd0);
    chk("rst_fcnt", frame_cnt_o, 16'd0);
    chk("rst_drop", drop_cnt_o, 16'd0);
    chk("rst_short", 16'(short_err_o), 16'd0);

    // Single burst, latency and content.
    m_ready_i = 1'b1;
    burst(16'h0000, 10);
    chk("lat_c0", 16'(m_valid_o), 16'd0);
    step();
    chk("lat_c1", 16'(m_valid_o), 16'd0);
    step();
    chk("lat_c2_valid", 16'(m_valid_o), 16'd1);
    chk("lat_c2_data", m_data_o, 16'hEB90);
    collect(40, 0);
    check_frame("f1", 16'h0000, 16'd0);
    chk("f1_sum_const", got[12], 16'h0037);
    chk("f1_fcnt", frame_cnt_o, 16'd1);

    // Four back-to-back bursts with the sink stalled.
    do_reset();
    m_ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      for (int i = 1; i <= 10; i++) begin
        wr_en_i  = 1'b1;
        wr_din_i = 16'(b * 256 + i);
        step();
      end
    end
    wr_en_i = 1'b0;
    step();
    step();
    chk("bb_drop", drop_cnt_o, 16'd1);
    chk("bb_stall_valid", 16'(m_valid_o), 16'd1);
    chk("bb_stall_data", m_data_o, 16'hEB90);
    chk("bb_short", 16'(short_err_o), 16'd0);
    m_ready_i = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      collect(40, 0);
      check_frame($sformatf("bb%0d", b), 16'(b * 256),
                  16'(b - 1));
      if (b > 1) chk($sformatf("bb%0d_gap", b), 16'(gap), 16'd0);
    end
    step();
    chk("bb_idle", 16'(m_valid_o), 16'd0);
    chk("bb_fcnt", frame_cnt_o, 16'd3);

    // Short burst then a good one.
    do_reset();
    burst(16'h0700, 6);
    step();
    chk("short_pulse", 16'(short_err_o), 16'd1);
    step();
    chk("short_clear", 16'(short_err_o), 16'd0);
    for (int i = 0; i < 4; i++) step();
    chk("short_noframe", 16'(m_valid_o), 16'd0);
    chk("short_fcnt", frame_cnt_o, 16'd0);
    burst(16'h0800, 10);
    collect(40, 0);
    check_frame("sf", 16'h0800, 16'd0);

    // Stalls during a frame.
    do_reset();
    m_ready_i = 1'b0;
    burst(16'h5A00, 10);
    collect(80, 1);
    check_frame("st", 16'h5A00, 16'd0);
    chk("st_fcnt", frame_cnt_o, 16'd1);

    // Reset mid-payload.
    do_reset();
    m_ready_i = 1'b1;
    burst(16'h3300, 10);
    step();
    step();
    chk("mr_head", m_data_o, 16'hEB90);
    step();
    step();
    step();
    chk("mr_pay", m_data_o, 16'h3302);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mr_valid", 16'(m_valid_o), 16'd0);
    chk("mr_data", m_data_o, 16'h0000);
    chk("mr_last", 16'(m_last_o), 16'd0);
    chk("mr_fcnt", frame_cnt_o, 16'd0);
    chk("mr_drop", drop_cnt_o, 16'd0);
    chk("mr_short", 16'(short_err_o), 16'd0);
    for (int i = 0; i < 5; i++) step();
    chk("mr_quiet", 16'(m_valid_o), 16'd0);
    burst(16'h4400, 10);
    collect(40, 0);
    check_frame("mr", 16'h4400, 16'd0);

    // One 20-word burst forms two frames.
    do_reset();
    m_ready_i = 1'b0;
    burst(16'h0000, 20);
    step();
    chk("long_short", 16'(short_err_o), 16'd0);
    chk("long_drop", drop_cnt_o, 16'd0);
    m_ready_i = 1'b1;
    collect(40, 0);
    check_frame("lg1", 16'h0000, 16'd0);
    collect(40, 0);
    check_frame("lg2", 16'h000A, 16'd1);
    chk("lg2_gap", 16'(gap), 16'd0);
    chk("long_fcnt", frame_cnt_o, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_frame_packer.md
Name: switch_frame_packer

Overview:
- Sits directly downstream of the GPIO-switch serializer, which emits one 10-word burst per acquisition pulse.
- Buffers the burst in an internal FIFO and wraps each complete burst into a framed packet: sync header, frame counter, payload, checksum.
- Emits the packet on a valid/ready stream toward the uplink/DMA path.
- Rejects short bursts and bursts that do not fit in the buffer, and reports both.

Parameters:
- WORDS_PER_FRAME, 10: payload words per frame, equal to the serializer burst length.
- FIFO_DEPTH, 32: payload buffer depth in words. Must be a power of 2 and at least 2*WORDS_PER_FRAME.
- SYNC_WORD, 16'hEB90: first word of every frame.

Ports:
- sys_clk_100m, in, 1: single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- wr_din_i, in, 16: payload word from the serializer.
- wr_en_i, in, 1: payload word strobe. A burst is a run of contiguous high cycles.
- m_data_o, out, 16: output stream word.
- m_valid_o, out, 1: output word valid.
- m_ready_i, in, 1: downstream ready.
- m_last_o, out, 1: marks the checksum word, which is the last word of the frame.
- frame_cnt_o, out, 16: number of frames fully emitted.
- drop_cnt_o, out, 16: bursts dropped because the FIFO lacked space. Saturates at 16'hFFFF.
- short_err_o, out, 1: one-cycle pulse when a burst ends before WORDS_PER_FRAME words.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs go to 0.
  - FIFO pointers and all counters clear; FSM returns to IDLE.
  - Reset mid-frame abandons the frame; no partial output is emitted afterwards.
- Write side:
  - Word index wi counts 0..WORDS_PER_FRAME-1.
  - At wi==0 with wr_en_i high, check free space = FIFO_DEPTH - committed words - tentative words.
    - free >= WORDS_PER_FRAME: accept the frame.
    - Otherwise: drop the whole frame. drop_cnt_o increments once, saturating, and the remaining words of that frame are ignored.
  - Accepted words are written at a tentative write pointer.
  - The WORDS_PER_FRAME-th word commits: committed pointer ← tentative pointer, and wi returns to 0.
  - Bursts longer than WORDS_PER_FRAME: the next word begins a new frame with a fresh space check.
  - wr_en_i falls with 0 < wi < WORDS_PER_FRAME: tentative words are discarded (tentative pointer ← committed pointer) and short_err_o pulses on the next cycle. A dropped frame that ends short does not pulse short_err_o.
- Read-side FSM:
  - IDLE → HEAD when committed occupancy >= WORDS_PER_FRAME.
  - HEAD: m_data_o = SYNC_WORD.
  - CNT: m_data_o = frame_cnt_o value (sequence number, starting at 0).
  - PAYLOAD: WORDS_PER_FRAME words in FIFO order.
  - SUM: m_data_o = 16-bit sum, mod 2^16, of that frame's payload words. m_last_o = 1.
  - After SUM: return to IDLE, or go straight to HEAD if another frame is committed.
  - Frame length is WORDS_PER_FRAME+3 words (13 at defaults).
- Handshake:
  - A word transfers on a cycle with m_valid_o && m_ready_i.
  - While m_valid_o && !m_ready_i, m_data_o and m_last_o hold stable.
  - m_valid_o never drops mid-frame: it stays high HEAD through SUM.
- frame_cnt_o increments on the SUM transfer and wraps from 16'hFFFF to 0.
- Latency: with m_ready_i high and the FIFO empty, the header is valid 2 cycles after the edge sampling the committing word. Back-to-back frames have no idle cycle between them.
- Simultaneous read and write: a FIFO read and a write/commit in the same cycle are both honoured. Free space uses the read pointer before the read (conservative).

Test Plan:
- Single burst 16'h0001..16'h000A, m_ready_i=1 → header 2 cycles after the 10th word. Stream EB90, 0000, 0001..000A, 0037 with m_last_o on 0037; frame_cnt_o=1.
- Four 10-word bursts back-to-back, m_ready_i=0 → bursts 1–3 accepted (30 words fit; the 3rd check sees free 12 >= 10). Burst 4 is dropped: drop_cnt_o=1. Raise m_ready_i → 3 frames with CNT words 0,1,2.
- 6-word burst → short_err_o pulses once; no frame emitted. Next 10-word burst emits a frame with CNT=0.
- Random m_ready_i toggling during a frame → m_data_o held stable while stalled; exactly 13 transfers; payload order preserved.
- rst_i asserted mid-PAYLOAD → next cycle all outputs 0. A subsequent burst emits a frame with CNT=0.
- 20-word continuous burst → two frames emitted, no short_err_o.
